// File: rtl/btn_event_ctrl.sv
// Button event controller: turns a debounced button level into short/long press events,
// counts presses and exposes them on a read-only register port with a level IRQ.
// Optional auto-repeat while held long: define BTN_EVT_REPEAT_EN.
module btn_event_ctrl #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 8,
    parameter int DUR_W         = 24
) (
    input  logic        clck_i,
    input  logic        rst_i,
    input  logic        btn_signal_i,
    input  logic        rd_en_i,
    input  logic [1:0]  addr_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

    localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);

    state_t             state_reg;
    logic               btn_q;
    logic               armed_reg;
    logic               short_evt_reg;
    logic               long_evt_reg;
    logic               rep_flag;
    logic [CNT_W-1:0]   press_cnt_reg;
    logic [DUR_W-1:0]   hold_cnt_reg;
    logic [DUR_W-1:0]   last_dur_reg;

`ifdef BTN_EVT_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0]   rep_cnt_reg;
    logic               rep_flag_reg;
    assign rep_flag = rep_flag_reg;
`else
    // Repeat disabled: the parameter is accepted so both builds share one interface.
    localparam int unused_repeat_cycles = REPEAT_CYCLES;
    assign rep_flag = 1'b0;
`endif

    logic               rise;
    logic               fall;
    logic               rd_status;
    logic               rd_press;
    logic               hold_at_long;
    logic [DUR_W-1:0]   hold_inc;
    logic [CNT_W-1:0]   press_bump;
    logic [31:0]        rd_data;

    // armed_reg blocks a level that was already high when reset released from looking like a rise.
    assign rise         = btn_signal_i & ~btn_q & armed_reg;
    assign fall         = ~btn_signal_i & btn_q;
    assign rd_status    = rd_en_i & (addr_i == 2'd0);
    assign rd_press     = rd_en_i & (addr_i == 2'd1);
    assign hold_at_long = ({{(32-DUR_W){1'b0}}, hold_cnt_reg} == LONG_LAST);
    assign hold_inc     = (&hold_cnt_reg) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
    // A clearing read on the same edge as an increment leaves exactly one press counted.
    assign press_bump   = rd_press ? CNT_W'(1)
                        : ((&press_cnt_reg) ? press_cnt_reg : press_cnt_reg + 1'b1);

    always_comb begin
        rd_data = '0;
        case (addr_i)
            2'd0:    rd_data = {27'b0, rep_flag, (state_reg == HOLD),
                                long_evt_reg, short_evt_reg, btn_q};
            2'd1:    rd_data = {{(32-CNT_W){1'b0}}, press_cnt_reg};
            2'd2:    rd_data = {{(32-DUR_W){1'b0}}, last_dur_reg};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clck_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            btn_q         <= 1'b0;
            armed_reg     <= 1'b0;
            short_evt_reg <= 1'b0;
            long_evt_reg  <= 1'b0;
            press_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
            last_dur_reg  <= '0;
            data_o        <= '0;
            irq_o         <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
            rep_cnt_reg   <= '0;
            rep_flag_reg  <= 1'b0;
`endif
        end else begin
            btn_q <= btn_signal_i;
            irq_o <= short_evt_reg | long_evt_reg;
            if (!btn_signal_i)
                armed_reg <= 1'b1;
            if (rd_en_i)
                data_o <= rd_data;

            // Clears first; any set below on the same edge overrides them.
            if (rd_status) begin
                short_evt_reg <= 1'b0;
                long_evt_reg  <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
                rep_flag_reg  <= 1'b0;
`endif
            end
            if (rd_press)
                press_cnt_reg <= '0;

            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_reg     <= PRESS;
                        hold_cnt_reg  <= DUR_W'(1);
                        press_cnt_reg <= press_bump;
                    end
                end
                PRESS: begin
                    if (fall) begin
                        state_reg     <= IDLE;
                        short_evt_reg <= 1'b1;
                        last_dur_reg  <= hold_cnt_reg;
                    end else if (btn_signal_i) begin
                        hold_cnt_reg <= hold_inc;
                        if (hold_at_long) begin
                            state_reg    <= HOLD;
                            long_evt_reg <= 1'b1;
`ifdef BTN_EVT_REPEAT_EN
                            rep_cnt_reg  <= '0;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (fall) begin
                        state_reg    <= IDLE;
                        last_dur_reg <= hold_cnt_reg;
                    end else if (btn_signal_i) begin
                        hold_cnt_reg <= hold_inc;
`ifdef BTN_EVT_REPEAT_EN
                        if (rep_cnt_reg == REP_LAST) begin
                            rep_cnt_reg   <= '0;
                            long_evt_reg  <= 1'b1;
                            rep_flag_reg  <= 1'b1;
                            press_cnt_reg <= press_bump;
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg + 1'b1;
                        end
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with LONG_CYCLES=10, REPEAT_CYCLES=4, CNT_W=4, DUR_W=8.
// Expected values track BTN_EVT_REPEAT_EN when it is defined for the build.
module tb_btn_event_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] data;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rep_cnt_exp;
    logic [31:0] rep_status_exp;

    btn_event_ctrl #(
        .LONG_CYCLES   (10),
        .REPEAT_CYCLES (4),
        .CNT_W         (4),
        .DUR_W         (8)
    ) dut (
        .clck_i       (clk),
        .rst_i        (rst_n),
        .btn_signal_i (btn),
        .rd_en_i      (rd_en),
        .addr_i       (addr),
        .data_o       (data),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed 0x%0h expected 0x%0h", n_vec, tag, obs, exp);
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        rd_en = 1'b1;
        addr  = a;
        tick();
        rd_en = 1'b0;
        check(tag, data, exp);
    endtask

    task automatic press(input int n);
        btn = 1'b1;
        repeat (n) tick();
        btn = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef BTN_EVT_REPEAT_EN
        rep_cnt_exp    = 32'd4;
        rep_status_exp = 32'h14;
`else
        rep_cnt_exp    = 32'd1;
        rep_status_exp = 32'h4;
`endif
        // Reset with the button already high
        btn = 1'b1;
        repeat (3) tick();
        check("reset_data", data, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (20) tick();
        btn = 1'b0;
        tick();
        rd(2'd1, "held_through_reset_cnt", 32'd0);
        rd(2'd0, "held_through_reset_status", 32'h0);
        check("held_through_reset_irq", {31'b0, irq}, 32'h0);

        // Short press of 5 cycles
        press(5);
        tick();
        check("short5_irq", {31'b0, irq}, 32'h1);
        rd(2'd2, "short5_dur", 32'd5);
        rd(2'd0, "short5_status", 32'h2);
        rd(2'd0, "short5_status_cleared", 32'h0);
        check("short5_irq_cleared", {31'b0, irq}, 32'h0);
        rd(2'd1, "short5_cnt", 32'd1);
        rd(2'd3, "addr3_zero", 32'd0);

        // Boundary: 9 cycles short, 10 cycles long
        press(9);
        rd(2'd0, "press9_status", 32'h2);
        press(10);
        tick();
        check("press10_irq", {31'b0, irq}, 32'h1);
        rd(2'd2, "press10_dur", 32'd10);
        rd(2'd0, "press10_status", 32'h4);

        // Hold visible while held
        btn = 1'b1;
        repeat (11) tick();
        rd(2'd0, "hold_status", 32'hD);
        btn = 1'b0;
        tick();
        rd(2'd2, "hold12_dur", 32'd12);
        rd(2'd0, "hold12_status", 32'h0);
        rd(2'd1, "three_press_cnt", 32'd3);

        // Counter saturation
        repeat (17) press(2);
        rd(2'd1, "sat_cnt", 32'd15);
        rd(2'd0, "sat_status", 32'h2);

        // STATUS read on the fall edge: set wins
        btn = 1'b1;
        repeat (3) tick();
        btn = 1'b0;
        rd(2'd0, "fall_read_status", 32'h1);
        rd(2'd0, "fall_read_after", 32'h2);

        // STATUS read on the rise edge
        btn = 1'b1;
        rd(2'd0, "rise_read_status", 32'h0);
        tick();
        tick();
        btn = 1'b0;
        tick();
        rd(2'd0, "rise_read_short", 32'h2);
        rd(2'd1, "rise_read_cnt", 32'd2);

        // PRESS_CNT read on a rise: increment wins
        press(2);
        btn = 1'b1;
        rd(2'd1, "cnt_rise_read_data", 32'd1);
        tick();
        btn = 1'b0;
        tick();
        rd(2'd1, "cnt_rise_read_after", 32'd1);

        // Async reset mid-HOLD
        btn = 1'b1;
        repeat (11) tick();
        rd(2'd1, "prereset_data", 32'd1);
        check("prereset_irq", {31'b0, irq}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_data", data, 32'h0);
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        rd(2'd1, "postreset_cnt", 32'd0);
        rd(2'd0, "postreset_status", 32'h1);
        rd(2'd2, "postreset_dur", 32'd0);
        btn = 1'b0;
        tick();
        press(5);
        rd(2'd1, "postreset_new_press", 32'd1);
        rd(2'd0, "postreset_new_status", 32'h2);

        // Long hold of 22 cycles (repeat behaviour when enabled)
        press(22);
        rd(2'd1, "hold22_cnt", rep_cnt_exp);
        rd(2'd0, "hold22_status", rep_status_exp);
        rd(2'd2, "hold22_dur", 32'd22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
